// File: rtl/button_event_gen.sv
// Button event generator: turns debounced levels into press, release,
// long-press and auto-repeat pulses plus a registered held level.
module button_event_gen #(
   parameter int WIDTH          = 1,
   parameter int TICK_CNT_MAX   = 25000,
   parameter int LONG_TICKS     = 2500,
   parameter int REPEAT_TICKS   = 500,
   parameter bit REPEAT_EN      = 1'b1,
   parameter int TICK_CNT_WIDTH = $clog2(TICK_CNT_MAX) + 1,
   parameter int HOLD_CNT_WIDTH =
      $clog2((LONG_TICKS > REPEAT_TICKS) ? LONG_TICKS : REPEAT_TICKS) + 1
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic [WIDTH-1:0] debounced_signal,
   output logic [WIDTH-1:0] press_pulse,
   output logic [WIDTH-1:0] release_pulse,
   output logic [WIDTH-1:0] long_pulse,
   output logic [WIDTH-1:0] repeat_pulse,
   output logic [WIDTH-1:0] held
);

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      PRESS = 2'd1,
      HOLD  = 2'd2
   } state_e;

   localparam logic [TICK_CNT_WIDTH-1:0] TICK_LAST =
      TICK_CNT_WIDTH'(TICK_CNT_MAX - 1);
   localparam logic [HOLD_CNT_WIDTH-1:0] LONG_LAST =
      HOLD_CNT_WIDTH'(LONG_TICKS - 1);
   localparam logic [HOLD_CNT_WIDTH-1:0] REP_LAST =
      HOLD_CNT_WIDTH'(REPEAT_TICKS - 1);

   logic [TICK_CNT_WIDTH-1:0] presc_q;
   logic [TICK_CNT_WIDTH-1:0] presc_d;
   logic                      tick;

   // Shared free-running prescaler; never restarted by a press.
   always_comb begin
      tick    = (presc_q == TICK_LAST);
      presc_d = tick ? '0 : presc_q + 1'b1;
   end

   // Prescaler register.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) presc_q <= '0;
      else        presc_q <= presc_d;
   end

   for (genvar i = 0; i < WIDTH; i++) begin : g_ch
      state_e                    state_q;
      state_e                    state_d;
      logic [HOLD_CNT_WIDTH-1:0] cnt_q;
      logic [HOLD_CNT_WIDTH-1:0] cnt_d;
      logic                      prev_q;
      logic                      rise;
      logic                      fall;
      logic                      press_q;
      logic                      press_d;
      logic                      rel_q;
      logic                      rel_d;
      logic                      long_q;
      logic                      long_d;
      logic                      rep_q;
      logic                      rep_d;
      logic                      held_q;
      logic                      held_d;

      // Next-state and pulse decode; a fall always wins over a tick.
      always_comb begin
         rise    = debounced_signal[i] & ~prev_q;
         fall    = ~debounced_signal[i] & prev_q;
         state_d = state_q;
         cnt_d   = cnt_q;
         press_d = 1'b0;
         rel_d   = 1'b0;
         long_d  = 1'b0;
         rep_d   = 1'b0;
         unique case (state_q)
            IDLE: begin
               if (rise) begin
                  press_d = 1'b1;
                  cnt_d   = '0;
                  state_d = PRESS;
               end
            end
            PRESS: begin
               if (fall) begin
                  rel_d   = 1'b1;
                  state_d = IDLE;
               end else if (tick && cnt_q == LONG_LAST) begin
                  long_d  = 1'b1;
                  cnt_d   = '0;
                  state_d = HOLD;
               end else if (tick) begin
                  cnt_d = cnt_q + 1'b1;
               end
            end
            HOLD: begin
               if (fall) begin
                  rel_d   = 1'b1;
                  state_d = IDLE;
               end else if (REPEAT_EN && tick && cnt_q == REP_LAST) begin
                  rep_d = 1'b1;
                  cnt_d = '0;
               end else if (REPEAT_EN && tick) begin
                  cnt_d = cnt_q + 1'b1;
               end
            end
            default: begin
               state_d = IDLE;
            end
         endcase
         held_d = (state_d != IDLE);
      end

      // Channel FSM, edge-detect history and registered outputs.
      always_ff @(posedge clk or negedge rst_n) begin
         if (!rst_n) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            prev_q  <= 1'b0;
            press_q <= 1'b0;
            rel_q   <= 1'b0;
            long_q  <= 1'b0;
            rep_q   <= 1'b0;
            held_q  <= 1'b0;
         end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            prev_q  <= debounced_signal[i];
            press_q <= press_d;
            rel_q   <= rel_d;
            long_q  <= long_d;
            rep_q   <= rep_d;
            held_q  <= held_d;
         end
      end

      assign press_pulse[i]   = press_q;
      assign release_pulse[i] = rel_q;
      assign long_pulse[i]    = long_q;
      assign repeat_pulse[i]  = rep_q;
      assign held[i]          = held_q;
   end

endmodule

// File: tb/tb_button_event_gen.sv
// Testbench for button_event_gen: run-length vector table plus
// a staggered two-channel sequence against a repeat-disabled copy.
module tb_button_event_gen;

   logic       clk;
   logic       rst_n;
   logic [1:0] din;

   logic [1:0] pr0, rl0, lg0, rp0, hd0;
   logic [1:0] pr1, rl1, lg1, rp1, hd1;

   int tests;
   int errors;

   typedef struct {
      bit         rst;
      logic [1:0] din;
      int         n;
      logic [9:0] exp;
   } vec_t;

   vec_t tbl[$];

   button_event_gen #(
      .WIDTH(2), .TICK_CNT_MAX(4), .LONG_TICKS(3),
      .REPEAT_TICKS(2), .REPEAT_EN(1'b1)
   ) u0 (
      .clk(clk), .rst_n(rst_n), .debounced_signal(din),
      .press_pulse(pr0), .release_pulse(rl0), .long_pulse(lg0),
      .repeat_pulse(rp0), .held(hd0)
   );

   button_event_gen #(
      .WIDTH(2), .TICK_CNT_MAX(4), .LONG_TICKS(3),
      .REPEAT_TICKS(2), .REPEAT_EN(1'b0)
   ) u1 (
      .clk(clk), .rst_n(rst_n), .debounced_signal(din),
      .press_pulse(pr1), .release_pulse(rl1), .long_pulse(lg1),
      .repeat_pulse(rp1), .held(hd1)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   function automatic logic [9:0] out0();
      return {pr0, rl0, lg0, rp0, hd0};
   endfunction

   function automatic logic [9:0] out1();
      return {pr1, rl1, lg1, rp1, hd1};
   endfunction

   task automatic chk(input string name, input logic [9:0] act,
                      input logic [9:0] exp);
      tests++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got pr/rl/lg/rp/hd=%b expected %b",
                  name, act, exp);
      end
   endtask

   function automatic void add(input bit r, input logic [1:0] d,
                               input int n, input logic [1:0] pr,
                               input logic [1:0] rl, input logic [1:0] lg,
                               input logic [1:0] rp, input logic [1:0] hd);
      vec_t v;
      v.rst = r;
      v.din = d;
      v.n   = n;
      v.exp = {pr, rl, lg, rp, hd};
      tbl.push_back(v);
   endfunction

   // Called at a negedge; asserts reset mid-cycle, holds 2 cycles.
   task automatic do_reset(input logic [1:0] d);
      din = d;
      #2 rst_n = 1'b0;
      #1;
      chk("rst_async_u0", out0(), 10'd0);
      chk("rst_async_u1", out1(), 10'd0);
      for (int k = 0; k < 2; k++) begin
         @(negedge clk);
         chk($sformatf("rst_hold%0d", k), out0(), 10'd0);
      end
      rst_n = 1'b1;
   endtask

   task automatic step(input logic [1:0] d);
      din = d;
      @(posedge clk);
      @(negedge clk);
   endtask

   initial begin
      logic [1:0] pr, lg, rp, hd;
      tests  = 0;
      errors = 0;
      rst_n  = 1'b1;
      din    = 2'b00;

      // Reset with both inputs high, then a short press on ch0.
      add(1, 2'b11, 0, 2'b00, 2'b00, 2'b00, 2'b00, 2'b00);
      add(0, 2'b11, 1, 2'b11, 2'b00, 2'b00, 2'b00, 2'b11);
      add(0, 2'b00, 1, 2'b00, 2'b11, 2'b00, 2'b00, 2'b00);
      add(0, 2'b00, 2, 2'b00, 2'b00, 2'b00, 2'b00, 2'b00);
      add(0, 2'b01, 1, 2'b01, 2'b00, 2'b00, 2'b00, 2'b01);
      add(0, 2'b01, 4, 2'b00, 2'b00, 2'b00, 2'b00, 2'b01);
      add(0, 2'b00, 1, 2'b00, 2'b01, 2'b00, 2'b00, 2'b00);
      add(0, 2'b00, 3, 2'b00, 2'b00, 2'b00, 2'b00, 2'b00);
      // Long hold on ch0: long at +11, repeats every 8,
      // release lands on a would-be repeat tick.
      add(1, 2'b00, 0, 2'b00, 2'b00, 2'b00, 2'b00, 2'b00);
      add(0, 2'b01, 1, 2'b01, 2'b00, 2'b00, 2'b00, 2'b01);
      add(0, 2'b01, 10, 2'b00, 2'b00, 2'b00, 2'b00, 2'b01);
      add(0, 2'b01, 1, 2'b00, 2'b00, 2'b01, 2'b00, 2'b01);
      add(0, 2'b01, 7, 2'b00, 2'b00, 2'b00, 2'b00, 2'b01);
      add(0, 2'b01, 1, 2'b00, 2'b00, 2'b00, 2'b01, 2'b01);
      add(0, 2'b01, 7, 2'b00, 2'b00, 2'b00, 2'b00, 2'b01);
      add(0, 2'b01, 1, 2'b00, 2'b00, 2'b00, 2'b01, 2'b01);
      add(0, 2'b01, 7, 2'b00, 2'b00, 2'b00, 2'b00, 2'b01);
      add(0, 2'b01, 1, 2'b00, 2'b00, 2'b00, 2'b01, 2'b01);
      add(0, 2'b01, 7, 2'b00, 2'b00, 2'b00, 2'b00, 2'b01);
      add(0, 2'b00, 1, 2'b00, 2'b01, 2'b00, 2'b00, 2'b00);
      add(0, 2'b00, 4, 2'b00, 2'b00, 2'b00, 2'b00, 2'b00);
      // Fall on the exact long-press tick: release only, back to IDLE.
      add(1, 2'b00, 0, 2'b00, 2'b00, 2'b00, 2'b00, 2'b00);
      add(0, 2'b01, 1, 2'b01, 2'b00, 2'b00, 2'b00, 2'b01);
      add(0, 2'b01, 10, 2'b00, 2'b00, 2'b00, 2'b00, 2'b01);
      add(0, 2'b00, 1, 2'b00, 2'b01, 2'b00, 2'b00, 2'b00);
      add(0, 2'b00, 4, 2'b00, 2'b00, 2'b00, 2'b00, 2'b00);
      add(0, 2'b01, 1, 2'b01, 2'b00, 2'b00, 2'b00, 2'b01);
      add(0, 2'b00, 1, 2'b00, 2'b01, 2'b00, 2'b00, 2'b00);
      add(0, 2'b00, 2, 2'b00, 2'b00, 2'b00, 2'b00, 2'b00);
      // Reset mid-HOLD on ch1 with input held: fresh press and timer.
      add(1, 2'b00, 0, 2'b00, 2'b00, 2'b00, 2'b00, 2'b00);
      add(0, 2'b10, 1, 2'b10, 2'b00, 2'b00, 2'b00, 2'b10);
      add(0, 2'b10, 10, 2'b00, 2'b00, 2'b00, 2'b00, 2'b10);
      add(0, 2'b10, 1, 2'b00, 2'b00, 2'b10, 2'b00, 2'b10);
      add(0, 2'b10, 3, 2'b00, 2'b00, 2'b00, 2'b00, 2'b10);
      add(1, 2'b10, 0, 2'b00, 2'b00, 2'b00, 2'b00, 2'b00);
      add(0, 2'b10, 1, 2'b10, 2'b00, 2'b00, 2'b00, 2'b10);
      add(0, 2'b10, 10, 2'b00, 2'b00, 2'b00, 2'b00, 2'b10);
      add(0, 2'b10, 1, 2'b00, 2'b00, 2'b10, 2'b00, 2'b10);
      add(0, 2'b00, 1, 2'b00, 2'b10, 2'b00, 2'b00, 2'b00);
      add(0, 2'b00, 2, 2'b00, 2'b00, 2'b00, 2'b00, 2'b00);

      @(negedge clk);
      for (int r = 0; r < tbl.size(); r++) begin
         if (tbl[r].rst) begin
            do_reset(tbl[r].din);
         end else begin
            for (int k = 0; k < tbl[r].n; k++) begin
               step(tbl[r].din);
               chk($sformatf("row%0d.%0d", r, k), out0(), tbl[r].exp);
            end
         end
      end

      // Staggered channels; ch1 rises on a tick edge, so its timing
      // lands on the next tick boundary (offset 4 edges).
      do_reset(2'b00);
      for (int e = 1; e <= 110; e++) begin
         step((e >= 4) ? 2'b11 : 2'b01);
         pr = (e == 1) ? 2'b01 : ((e == 4) ? 2'b10 : 2'b00);
         lg = 2'b00;
         if (e == 12) lg[0] = 1'b1;
         if (e == 16) lg[1] = 1'b1;
         rp = 2'b00;
         if (e >= 20 && (e - 20) % 8 == 0) rp[0] = 1'b1;
         if (e >= 24 && (e - 24) % 8 == 0) rp[1] = 1'b1;
         hd = (e >= 4) ? 2'b11 : 2'b01;
         chk($sformatf("stag_u0_e%0d", e), out0(),
             {pr, 2'b00, lg, rp, hd});
         chk($sformatf("norep_u1_e%0d", e), out1(),
             {pr, 2'b00, lg, 2'b00, hd});
      end
      step(2'b00);
      chk("stag_rel_u0", out0(), {2'b00, 2'b11, 6'd0});
      chk("stag_rel_u1", out1(), {2'b00, 2'b11, 6'd0});

      $display("[TB] %0d tests run, %0d failed", tests, errors);
      $finish;
   end

endmodule
